dmem_access_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the word-wide data memory. Shares one memory port

---
 rtl/dmem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates core and loader ports onto one synchronous-read
// word memory, with sub-word loads and read-modify-write sub-word stores.
module dmem_access_ctrl #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned MEM_AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic              c_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [2:0]        l_funct3,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_ack,
  output logic              l_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StErr} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;  // 0 = core, 1 = loader
  logic               last_q, last_d;    // port granted most recently
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [MEM_AW+1:0]  addr_q, addr_d;
  logic [31:0]        word_q, word_d;    // store data, later the merged RMW word
  logic [31:0]        rdata_q, rdata_d;

  logic        grant_l, sel_we, illegal, ack, err;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] shifted, load_ext, lane_mask, merged;
  logic [4:0]  lane_sh;

  // Reset leaves last_q = loader so a simultaneous first request goes to the core.
  always_comb begin
    grant_l   = l_req & (~c_req | ~last_q);
    sel_we    = grant_l ? l_we : c_we;
    sel_f3    = grant_l ? l_funct3 : c_funct3;
    sel_addr  = grant_l ? l_addr : c_addr;
    sel_wdata = grant_l ? l_wdata : c_wdata;
    illegal   = !(sel_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
              | (sel_we & sel_f3[2])
              | ((sel_f3[1:0] == 2'b01) & sel_addr[0])
              | ((sel_f3[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00))
              | (sel_addr[31:2] >= 30'(DEPTH));
  end

  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    shifted = mem_rdata >> lane_sh;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
    lane_mask = f3_q[0] ? 32'h0000_ffff : 32'h0000_00ff;
    merged    = (mem_rdata & ~(lane_mask << lane_sh)) | ((word_q & lane_mask) << lane_sh);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    word_d    = word_q;
    rdata_d   = rdata_q;
    ack       = 1'b0;
    err       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_rdata = rdata_q;
    case (state_q)
      StIdle: begin
        if (c_req | l_req) begin
          owner_d = grant_l;
          last_d  = grant_l;
          we_d    = sel_we;
          f3_d    = sel_f3;
          addr_d  = sel_addr[MEM_AW+1:0];
          word_d  = sel_wdata;
          if (illegal)                          state_d = StErr;
          else if (sel_we && sel_f3 == 3'b010) state_d = StWr;
          else                                  state_d = StRd;
        end
      end
      StRd: begin
        mem_re   = 1'b1;
        mem_addr = addr_q[MEM_AW+1:2];
        state_d  = StRdw;
      end
      StRdw: begin
        if (!we_q) begin
          ack       = 1'b1;
          rdata_d   = load_ext;
          rsp_rdata = load_ext;
          state_d   = StIdle;
        end else begin
          word_d  = merged;
          state_d = StWr;
        end
      end
      StWr: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q[MEM_AW+1:2];
        mem_wdata = word_q;
        ack       = 1'b1;
        state_d   = StIdle;
      end
      StErr: begin
        ack     = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    c_ack = ack & ~owner_q;
    c_err = err & ~owner_q;
    l_ack = ack & owner_q;
    l_err = err & owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a synchronous-read word memory model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, l_req, l_we;
  logic [2:0]  c_funct3, l_funct3;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_ack, c_err, l_ack, l_err;
  logic [31:0] rsp_rdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  int both_hi = 0, wrong_ack = 0, idle_bad = 0, rd_cnt, wr_cnt;
  logic [31:0] wr_addr, wr_data;

  int          lat;
  logic        err;
  logic [31:0] rd;
  int          n_ack;
  logic [3:0]  order;

  dmem_access_ctrl #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err),
    .l_req(l_req), .l_we(l_we), .l_funct3(l_funct3), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_err(l_err),
    .rsp_rdata(rsp_rdata), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle protocol observations, sampled 1 time unit after the rising edge.
  task automatic observe();
    if (mem_re && mem_we) both_hi++;
    if (!mem_re && !mem_we && (mem_addr != 0 || mem_wdata != 0)) idle_bad++;
    if (mem_we) begin wr_addr = 32'(mem_addr); wr_data = mem_wdata; wr_cnt++; end
    if (mem_re) rd_cnt++;
  endtask

  // Issue one request at the start of an idle cycle (cycle 0) and wait for its ack.
  task automatic do_op(input bit lport, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int olat, output logic oerr, output logic [31:0] ord);
    @(posedge clk); #1;
    if (lport) begin l_req = 1; l_we = we; l_funct3 = f3; l_addr = addr; l_wdata = wd; end
    else       begin c_req = 1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd; end
    olat = -1; oerr = 1'bx; ord = 'x; rd_cnt = 0; wr_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      observe();
      if (lport ? c_ack : l_ack) wrong_ack++;
      if (lport ? l_ack : c_ack) begin
        olat = k; oerr = lport ? l_err : c_err; ord = rsp_rdata;
        break;
      end
    end
    c_req = 0; l_req = 0;
  endtask

  initial begin
    rst_n = 1; c_req = 0; l_req = 0; c_we = 0; l_we = 0; c_funct3 = 0; l_funct3 = 0;
    c_addr = 0; l_addr = 0; c_wdata = 0; l_wdata = 0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {28'h0, c_ack, l_ack, mem_re, mem_we}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    @(negedge clk) rst_n = 1;

    // Word store, then byte RMW and sub-word loads on the core port.
    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, lat, err, rd);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_err", {31'h0, err}, 32'h0);
    check("sw_addr", wr_addr, 32'h4);
    check("sw_data", wr_data, 32'hDEADBEEF);
    do_op(0, 1, 3'b000, 32'h11, 32'h55, lat, err, rd);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_merged", wr_data, 32'hDEAD55EF);
    check("sb_reads", 32'(rd_cnt), 32'd1);
    do_op(0, 0, 3'b000, 32'h11, 32'h0, lat, err, rd);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_data", rd, 32'h00000055);
    do_op(0, 0, 3'b001, 32'h12, 32'h0, lat, err, rd);
    check("lh_data", rd, 32'hFFFFDEAD);
    do_op(0, 0, 3'b101, 32'h12, 32'h0, lat, err, rd);
    check("lhu_data", rd, 32'h0000DEAD);
    do_op(0, 0, 3'b000, 32'h13, 32'h0, lat, err, rd);
    check("lb_neg", rd, 32'hFFFFFFDE);
    do_op(0, 0, 3'b100, 32'h10, 32'h0, lat, err, rd);
    check("lbu_data", rd, 32'h000000EF);

    // Illegal requests: misaligned LW, misaligned SH, out of range, bad funct3.
    do_op(0, 0, 3'b010, 32'h13, 32'h0, lat, err, rd);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_err", {31'h0, err}, 32'h1);
    check("lw_mis_strobe", 32'(rd_cnt + wr_cnt), 32'd0);
    do_op(0, 1, 3'b001, 32'h01, 32'h1234, lat, err, rd);
    check("sh_mis_lat", 32'(lat), 32'd1);
    check("sh_mis_err", {31'h0, err}, 32'h1);
    check("sh_mis_strobe", 32'(rd_cnt + wr_cnt), 32'd0);
    do_op(1, 0, 3'b010, 32'h400, 32'h0, lat, err, rd);
    check("range_lat", 32'(lat), 32'd1);
    check("range_err", {31'h0, err}, 32'h1);
    check("range_strobe", 32'(rd_cnt + wr_cnt), 32'd0);
    do_op(0, 0, 3'b011, 32'h10, 32'h0, lat, err, rd);
    check("f3_lat", 32'(lat), 32'd1);
    check("f3_err", {31'h0, err}, 32'h1);
    check("f3_strobe", 32'(rd_cnt + wr_cnt), 32'd0);
    do_op(0, 1, 3'b100, 32'h10, 32'h0, lat, err, rd);
    check("sbu_err", {31'h0, err}, 32'h1);

    // Back-to-back LW then SW on the loader port.
    do_op(1, 0, 3'b010, 32'h10, 32'h0, lat, err, rd);
    check("l_lw_lat", 32'(lat), 32'd2);
    check("l_lw_data", rd, 32'hDEAD55EF);
    do_op(1, 1, 3'b010, 32'h14, 32'hCAFEF00D, lat, err, rd);
    check("l_sw_b2b_lat", 32'(lat), 32'd1);
    check("rdata_hold", rsp_rdata, 32'hDEAD55EF);
    do_op(0, 0, 3'b010, 32'h14, 32'h0, lat, err, rd);
    check("lw_after_l_sw", rd, 32'hCAFEF00D);

    // Both ports requesting from reset: grants must alternate C, L, C, L.
    rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_funct3 = 3'b010; c_addr = 32'h20; c_wdata = 32'h0000000A;
    l_req = 1; l_we = 1; l_funct3 = 3'b010; l_addr = 32'h24; l_wdata = 32'h0000000B;
    n_ack = 0; order = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      observe();
      if (c_ack && l_ack) wrong_ack++;
      if (c_ack) begin order = {order[2:0], 1'b0}; n_ack++; end
      if (l_ack) begin order = {order[2:0], 1'b1}; n_ack++; end
      if (n_ack >= 4) break;
    end
    c_req = 0; l_req = 0;
    check("rr_count", 32'(n_ack), 32'd4);
    check("rr_order", {28'h0, order}, 32'h5);
    do_op(1, 0, 3'b010, 32'h20, 32'h0, lat, err, rd);
    check("rr_c_word", rd, 32'h0000000A);
    do_op(0, 0, 3'b010, 32'h24, 32'h0, lat, err, rd);
    check("rr_l_word", rd, 32'h0000000B);

    // Reset during the RDW cycle of a byte store must not write.
    do_op(0, 1, 3'b010, 32'h30, 32'h11223344, lat, err, rd);
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_funct3 = 3'b000; c_addr = 32'h31; c_wdata = 32'hAA;
    @(posedge clk); #1;
    check("rmw_rd_strobe", {31'h0, mem_re}, 32'h1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rst_rdw_outputs", {29'h0, c_ack, mem_re, mem_we}, 32'h0);
    c_req = 0;
    @(posedge clk); #1;
    check("rst_hold_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk) rst_n = 1;
    do_op(0, 0, 3'b010, 32'h30, 32'h0, lat, err, rd);
    check("rst_word_kept", rd, 32'h11223344);

    check("never_both_strobes", 32'(both_hi), 32'd0);
    check("no_nonowner_ack", 32'(wrong_ack), 32'd0);
    check("idle_bus_zero", 32'(idle_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
